// File: rtl/estimate_seq.sv
// estimate_seq: layer sequencer issuing command/address/data to the 32-lane estimate datapath
module estimate_seq #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int CNT_W = 16,
   parameter int LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode8,
   input  logic [CNT_W-1:0]  n_acc,
   input  logic [CNT_W-1:0]  n_pool,
   input  logic [CNT_W-1:0]  n_grp,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] in_base,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [ADDR_W-1:0] in_raddr,
   input  logic [DATA_W-1:0] in_rdata,
   output logic [2:0]        est_com,
   output logic [ADDR_W-1:0] est_addr,
   output logic [DATA_W-1:0] est_data,
   input  logic [31:0]       est_activ,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_activ
);
   localparam int DW = $clog2(LAT + 1);
   typedef enum logic [2:0] {IDLE, INI, ACC, POOL, NORM, ACTIV, DRAIN, FIN} state_t;
   state_t state, nxt;
   logic m8;
   logic [CNT_W-1:0] acc_n, pool_n, grp_n, k, p, g;
   logic [ADDR_W-1:0] base_in, gb;
   logic [DW-1:0] d;
   logic cfg_ok, accept, last_drain, capture, last_grp;
   assign cfg_ok = n_acc != '0 && n_pool != '0 && n_grp != '0;
   assign accept = state == IDLE && start && cfg_ok;
   assign last_drain = state == DRAIN && d == DW'(LAT - 1);
   assign capture = last_drain && (!out_valid || out_ready);
   assign last_grp = g == grp_n - CNT_W'(1);
   assign est_data = state == ACC ? in_rdata : '0;
   assign busy = state != IDLE;
   assign done = state == FIN;
   // state register; reset aborts any layer in flight
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   // next state: one command per cycle, last DRAIN waits while the result slot is occupied
   always_comb begin
      nxt = state;
      case (state)
         IDLE:  nxt = accept ? INI : IDLE;
         INI:   nxt = ACC;
         ACC:   nxt = k == acc_n - CNT_W'(1) ? POOL : ACC;
         POOL:  nxt = p == pool_n - CNT_W'(1) ? NORM : ACC;
         NORM:  nxt = ACTIV;
         ACTIV: nxt = DRAIN;
         DRAIN: nxt = !capture ? DRAIN : last_grp ? FIN : INI;
         FIN:   nxt = IDLE;
      endcase
   end
   // command and ROM address for the current state; NOP everywhere else
   always_comb begin
      est_com = 3'd7;
      est_addr = '0;
      case (state)
         INI:   est_com = 3'd0;
         ACC:   begin est_com = m8 ? 3'd5 : 3'd1; est_addr = gb + ADDR_W'(k); end
         POOL:  est_com = 3'd2;
         NORM:  begin est_com = m8 ? 3'd6 : 3'd3; est_addr = gb + ADDR_W'(acc_n); end
         ACTIV: est_com = 3'd4;
         default: ;
      endcase
   end
   // config latch, loop counters, read pointer one word ahead of ACC, and the result slot
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m8 <= 1'b0;
         acc_n <= '0;
         pool_n <= '0;
         grp_n <= '0;
         base_in <= '0;
         gb <= '0;
         k <= '0;
         p <= '0;
         g <= '0;
         d <= '0;
         in_raddr <= '0;
         cfg_err <= 1'b0;
         out_valid <= 1'b0;
         out_activ <= '0;
      end else begin
         cfg_err <= state == IDLE && start && !cfg_ok;
         if (accept) begin
            m8 <= mode8;
            acc_n <= n_acc;
            pool_n <= n_pool;
            grp_n <= n_grp;
            base_in <= in_base;
            gb <= w_base;
            g <= '0;
            in_raddr <= in_base;
         end
         if (state == INI) begin
            k <= '0;
            p <= '0;
         end
         if (state == ACC) k <= k + CNT_W'(1);
         if (state == POOL) begin
            k <= '0;
            p <= p + CNT_W'(1);
         end
         if (state == ACTIV) d <= '0;
         if (state == DRAIN && !last_drain) d <= d + DW'(1);
         if (nxt == ACC) in_raddr <= in_raddr + ADDR_W'(1);
         if (capture) begin
            out_activ <= est_activ;
            g <= g + CNT_W'(1);
            gb <= gb + ADDR_W'(acc_n) + ADDR_W'(1);
            in_raddr <= base_in;
         end
         out_valid <= capture || (out_valid && !out_ready);
      end
endmodule
